// File: rtl/ulpi_defs.sv
// Shared ULPI register-access definitions: FSM states, TX CMD prefixes,
// bus idle value and well-known register addresses.
package ulpi_defs;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CMD        = 3'd1,
    ST_WDATA      = 3'd2,
    ST_STOP       = 3'd3,
    ST_RD_TURN    = 3'd4,
    ST_RD_DATA    = 3'd5,
    ST_RD_END     = 3'd6,
    ST_ABORT_WAIT = 3'd7
  } ulpi_state_e;

  typedef struct packed {
    logic       write;
    logic [5:0] addr;
    logic [7:0] wdata;
  } ulpi_req_t;

  localparam logic [1:0] TXCMD_REGW = 2'b10;
  localparam logic [1:0] TXCMD_REGR = 2'b11;

  localparam logic [7:0] ULPI_IDLE = 8'h00;

  localparam logic [5:0] VENDOR_ID_LOW  = 6'h00;
  localparam logic [5:0] VENDOR_ID_HIGH = 6'h01;

  function automatic logic [7:0] txcmd(
    input logic       write,
    input logic [5:0] addr
  );
    return {(write ? TXCMD_REGW : TXCMD_REGR), addr};
  endfunction

  // States in which the engine is waiting on the PHY and may stall.
  function automatic logic waits_on_phy(input ulpi_state_e s);
    return (s == ST_CMD) || (s == ST_WDATA) ||
           (s == ST_RD_TURN) || (s == ST_RD_END);
  endfunction

  function automatic logic link_owns_bus(input ulpi_state_e s);
    return (s == ST_IDLE) || (s == ST_CMD) ||
           (s == ST_WDATA) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/ulpi_reg_timer.sv
// Progress watchdog: clears or loads on demand, counts while enabled,
// flags expiry on the last permitted cycle.
module ulpi_reg_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en & (cnt_q == LAST);

endmodule

// File: rtl/ulpi_reg_access.sv
// ULPI link-side register read/write engine (TX CMD/NXT/DIR/STP).
// Define ULPI_RXCMD_CAPTURE_EN to latch RX CMD bytes from the PHY.
module ulpi_reg_access
  import ulpi_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       rxcmd_valid,
  output logic [7:0] rxcmd_byte
);

  ulpi_state_e state_q, state_d;
  ulpi_req_t   req_q, req_d;
  logic        drive_q, drive_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        req_fire;
  logic        tmo;
  logic        expired;
  logic        tmr_en;
  logic        tmr_clr;

  assign req_ready = (state_q == ST_IDLE) & ~reset;
  assign req_fire  = req_valid & req_ready;

  assign tmr_en  = waits_on_phy(state_q);
  assign tmr_clr = (state_d != state_q);

  ulpi_reg_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clr),
    .en      (tmr_en),
    .load    (1'b0),
    .load_val(16'h0000),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      drive_q     <= drive_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rdata_q     <= rdata_d;
    end
  end

  // Handshake progress always wins over the watchdog in the same cycle.
  always_comb begin : next_state
    state_d = state_q;
    tmo     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_fire) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (ulpi_dir) begin
          state_d = ST_ABORT_WAIT;
        end else if (ulpi_nxt) begin
          state_d = req_q.write ? ST_WDATA : ST_RD_TURN;
        end else if (expired) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (ulpi_nxt) begin
          state_d = ST_STOP;
        end else if (expired) begin
          tmo     = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        state_d = ST_IDLE;
      end
      ST_RD_TURN: begin
        if (ulpi_dir) begin
          state_d = ulpi_nxt ? ST_ABORT_WAIT : ST_RD_DATA;
        end else if (expired) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_DATA: begin
        state_d = ST_RD_END;
      end
      ST_RD_END: begin
        if (!ulpi_dir) begin
          state_d = ST_IDLE;
        end else if (expired) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ABORT_WAIT: begin
        if (!ulpi_dir) state_d = ST_CMD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin : outputs
    ulpi_stp      = 1'b0;
    ulpi_data_out = ULPI_IDLE;
    unique case (state_q)
      ST_CMD:   ulpi_data_out = txcmd(req_q.write, req_q.addr);
      ST_WDATA: ulpi_data_out = req_q.wdata;
      ST_STOP:  ulpi_stp      = 1'b1;
      default:  ;
    endcase

    req_d = req_q;
    if (req_fire) begin
      req_d.write = req_write;
      req_d.addr  = req_addr;
      req_d.wdata = req_wdata;
    end

    drive_d = link_owns_bus(state_d);

    rsp_valid_d = tmo
      | ((state_q == ST_WDATA) && (state_d == ST_STOP))
      | ((state_q == ST_RD_END) && (state_d == ST_IDLE));
    rsp_error_d = tmo;

    rdata_d = (state_q == ST_RD_DATA) ? ulpi_data_in : rdata_q;
  end

  assign ulpi_data_oe = drive_q & ~ulpi_dir;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_error    = rsp_error_q;
  assign rsp_rdata    = rdata_q;

`ifdef ULPI_RXCMD_CAPTURE_EN
  logic       dir_prev_q, dir_prev_d;
  logic       rxv_q, rxv_d;
  logic [7:0] rxb_q, rxb_d;

  // A DIR-high cycle that follows another DIR-high cycle carries an RX CMD
  // unless NXT marks data or the engine is taking its own read byte.
  always_comb begin
    dir_prev_d = ulpi_dir;
    rxv_d      = ulpi_dir & ~ulpi_nxt & dir_prev_q &
                 (state_q != ST_RD_DATA);
    rxb_d      = rxv_d ? ulpi_data_in : rxb_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_prev_q <= 1'b0;
      rxv_q      <= 1'b0;
      rxb_q      <= 8'h00;
    end else begin
      dir_prev_q <= dir_prev_d;
      rxv_q      <= rxv_d;
      rxb_q      <= rxb_d;
    end
  end

  assign rxcmd_valid = rxv_q;
  assign rxcmd_byte  = rxb_q;
`else
  assign rxcmd_valid = 1'b0;
  assign rxcmd_byte  = 8'h00;
`endif

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Bench for ulpi_reg_access: scripted PHY, vector table, random
// transactions against a register-file model, timeout and reset cases.
module tb_ulpi_reg_access;
  import ulpi_defs::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;
  logic [7:0] ulpi_data_in;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe;
  logic       rxcmd_valid;
  logic [7:0] rxcmd_byte;

  int errors = 0;
  int checks = 0;

  logic [7:0] phy_regs [64];
  logic [7:0] model    [64];
  logic [7:0] last_rd;

  typedef struct {
    bit         wr;
    logic [5:0] a;
    logic [7:0] wd;
    int         dcmd;
    int         ddat;
    int         ab;
    bit         rab;
    logic [7:0] ecmd;
    logic [7:0] erd;
  } vec_t;

  vec_t vt [9];

  ulpi_reg_access #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .ulpi_dir     (ulpi_dir),
    .ulpi_nxt     (ulpi_nxt),
    .ulpi_stp     (ulpi_stp),
    .ulpi_data_in (ulpi_data_in),
    .ulpi_data_out(ulpi_data_out),
    .ulpi_data_oe (ulpi_data_oe),
    .rxcmd_valid  (rxcmd_valid),
    .rxcmd_byte   (rxcmd_byte)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction with a scripted PHY; expectations come from the caller.
  task automatic txn(input bit wr, input logic [5:0] a,
                     input logic [7:0] wd, input int dcmd,
                     input int ddat, input int ab, input bit rab,
                     input logic [7:0] ecmd, input logic [7:0] erd);
    logic [7:0] cap;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    #1;
    chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    #1;
    chk("txcmd", ulpi_data_out, ecmd);
    chk("txcmd_oe", ulpi_data_oe, 1);
    if (ab > 0) begin
      ulpi_dir     = 1'b1;
      ulpi_data_in = 8'h4D;
      #1;
      chk("abort_oe_same_cycle", ulpi_data_oe, 0);
      repeat (ab) tick();
      chk("abort_oe_held", ulpi_data_oe, 0);
      ulpi_dir = 1'b0;
      tick();
      #1;
      chk("txcmd_reissue", ulpi_data_out, ecmd);
      chk("txcmd_reissue_oe", ulpi_data_oe, 1);
`ifdef ULPI_RXCMD_CAPTURE_EN
      chk("rxcmd_byte", rxcmd_byte, 8'h4D);
`else
      chk("rxcmd_off", {rxcmd_valid, rxcmd_byte}, 0);
`endif
    end
    repeat (dcmd) begin
      tick();
      chk("txcmd_hold", ulpi_data_out, ecmd);
    end
    ulpi_nxt = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    if (wr) begin
      #1;
      chk("wdata_bus", ulpi_data_out, wd);
      chk("wdata_oe", ulpi_data_oe, 1);
      repeat (ddat) tick();
      cap      = ulpi_data_out;
      ulpi_nxt = 1'b1;
      tick();
      ulpi_nxt = 1'b0;
      #1;
      chk("stp", ulpi_stp, 1);
      chk("stp_data", ulpi_data_out, 8'h00);
      chk("wr_rsp", {rsp_valid, rsp_error}, 2'b10);
      if (ulpi_stp) phy_regs[a] = cap;
      tick();
      chk("wr_done", {rsp_valid, ulpi_stp}, 0);
    end else begin
      if (rab) begin
        ulpi_dir = 1'b1;
        ulpi_nxt = 1'b1;
        #1;
        chk("rd_abort_oe", ulpi_data_oe, 0);
        tick();
        ulpi_nxt = 1'b0;
        tick();
        ulpi_dir = 1'b0;
        tick();
        #1;
        chk("rd_retry_txcmd", ulpi_data_out, ecmd);
        ulpi_nxt = 1'b1;
        tick();
        ulpi_nxt = 1'b0;
      end
      ulpi_dir = 1'b1;
      #1;
      chk("turn_oe", ulpi_data_oe, 0);
      tick();
      ulpi_data_in = phy_regs[a];
      tick();
      ulpi_data_in = 8'hEE;
      #1;
      chk("rd_wait_oe", ulpi_data_oe, 0);
      chk("rd_no_early_rsp", rsp_valid, 0);
      tick();
      ulpi_dir = 1'b0;
      tick();
      chk("rd_rsp", {rsp_valid, rsp_error}, 2'b10);
      chk("rd_data", rsp_rdata, erd);
      chk("rd_ready", req_ready, 1);
      last_rd = erd;
      tick();
      chk("rd_done", rsp_valid, 0);
    end
  endtask

  initial begin
    bit         wr;
    logic [5:0] a;
    logic [7:0] wd;
    int         dc, dd, ab;
    bit         rab;
    logic [7:0] ec;

    for (int i = 0; i < 64; i++) begin
      phy_regs[i] = 8'(i * 3 + 7);
      model[i]    = 8'(i * 3 + 7);
    end
    phy_regs[VENDOR_ID_LOW]  = 8'h24;
    model[VENDOR_ID_LOW]     = 8'h24;
    phy_regs[VENDOR_ID_HIGH] = 8'h04;
    model[VENDOR_ID_HIGH]    = 8'h04;
    last_rd = 8'h00;

    vt[0] = '{1'b0, 6'h01, 8'h00, 1, 0, 0, 1'b0, 8'hC1, 8'h04};
    vt[1] = '{1'b1, 6'h0A, 8'h55, 2, 2, 0, 1'b0, 8'h8A, 8'h00};
    vt[2] = '{1'b0, 6'h0A, 8'h00, 0, 0, 0, 1'b0, 8'hCA, 8'h55};
    vt[3] = '{1'b0, 6'h00, 8'h00, 0, 0, 0, 1'b0, 8'hC0, 8'h24};
    vt[4] = '{1'b1, 6'h3F, 8'hC3, 0, 1, 5, 1'b0, 8'hBF, 8'h00};
    vt[5] = '{1'b0, 6'h3F, 8'h00, 1, 0, 5, 1'b0, 8'hFF, 8'hC3};
    vt[6] = '{1'b0, 6'h01, 8'h00, 0, 0, 0, 1'b1, 8'hC1, 8'h04};
    vt[7] = '{1'b1, 6'h20, 8'h7E, 0, 0, 0, 1'b0, 8'hA0, 8'h00};
    vt[8] = '{1'b0, 6'h20, 8'h00, 3, 0, 0, 1'b0, 8'hE0, 8'h7E};

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 6'h00;
    req_wdata    = 8'h00;
    ulpi_dir     = 1'b0;
    ulpi_nxt     = 1'b0;
    ulpi_data_in = 8'h00;
    repeat (3) tick();
    chk("rst_outputs",
        {ulpi_stp, ulpi_data_oe, rsp_valid, rsp_error, req_ready}, 0);
    chk("rst_bus", ulpi_data_out, 8'h00);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_rxcmd", {rxcmd_valid, rxcmd_byte}, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("ready_after_rst", req_ready, 1);

    for (int i = 0; i < 9; i++) begin
      txn(vt[i].wr, vt[i].a, vt[i].wd, vt[i].dcmd, vt[i].ddat,
          vt[i].ab, vt[i].rab, vt[i].ecmd, vt[i].erd);
      if (vt[i].wr) model[vt[i].a] = vt[i].wd;
    end

    // Read that never sees NXT: error response 8 cycles after CMD entry.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 6'h02;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();
    chk("tmo_not_early", rsp_valid, 0);
    tick();
    chk("tmo_cmd_rsp", {rsp_valid, rsp_error}, 2'b11);
    chk("tmo_rdata_kept", rsp_rdata, last_rd);
    chk("tmo_cmd_ready", req_ready, 1);
    tick();
    chk("tmo_pulse_once", rsp_valid, 0);

    // Write whose data phase is never accepted: timeout goes through STOP.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 6'h11;
    req_wdata = 8'hA5;
    tick();
    req_valid = 1'b0;
    ulpi_nxt  = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    repeat (7) tick();
    chk("tmo_wdata_wait", {ulpi_stp, rsp_valid}, 0);
    tick();
    chk("tmo_wdata_stp", ulpi_stp, 1);
    chk("tmo_wdata_rsp", {rsp_valid, rsp_error}, 2'b11);
    tick();
    chk("tmo_wdata_idle", {ulpi_stp, rsp_valid, req_ready}, 3'b001);

    for (int n = 0; n < 30; n++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = 6'($urandom_range(0, 63));
      wd  = 8'($urandom_range(0, 255));
      dc  = int'($urandom_range(0, 3));
      dd  = int'($urandom_range(0, 3));
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 5)) : 0;
      rab = !wr && ($urandom_range(0, 5) == 0);
      ec  = wr ? 8'(8'h80 + a) : 8'(8'hC0 + a);
      txn(wr, a, wd, dc, dd, ab, rab, ec, model[a]);
      if (wr) model[a] = wd;
      repeat (int'($urandom_range(0, 2))) tick();
    end

    // Reset while the read byte is on the bus: request is dropped silently.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = VENDOR_ID_HIGH;
    tick();
    req_valid = 1'b0;
    ulpi_nxt  = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    ulpi_dir = 1'b1;
    tick();
    ulpi_data_in = 8'h04;
    reset        = 1'b1;
    #1;
    chk("midrst_ctrl",
        {ulpi_stp, ulpi_data_oe, rsp_valid, rsp_error, req_ready}, 0);
    chk("midrst_bus", ulpi_data_out, 8'h00);
    chk("midrst_rdata", rsp_rdata, 8'h00);
    ulpi_dir = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
    last_rd = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    txn(1'b0, VENDOR_ID_HIGH, 8'h00, 0, 0, 0, 1'b0, 8'hC1,
        model[VENDOR_ID_HIGH]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_access.md
Name: ulpi_reg_access

Overview:
- ULPI link-side register-access engine between the ULPI PHY pins and the UART byte feeder.
- Accepts one register read or write request at a time and runs the ULPI TX CMD / NXT / DIR / STP handshake, including bus turnaround and PHY aborts.
- Returns the read byte, or a completion pulse for writes, to the downstream consumer, which forwards it to the UART transmitter.
- Runs entirely in the ULPI 60 MHz domain; the top level connects the PHY CLKOUT to clk.

Parameters:
TIMEOUT_CYCLES, 255, cycles without handshake progress before a request is abandoned with rsp_error=1 (legal range 4..65535)

Ports:
clk  input  1  ULPI 60 MHz clock (PHY CLKOUT); single clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  engine can accept a request this cycle
req_write  input  1  1=register write, 0=register read
req_addr  input  6  ULPI immediate register address
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  8  read data; holds until the next completed read
rsp_error  output  1  qualifies rsp_valid; 1=timeout
ulpi_dir  input  1  PHY DIR
ulpi_nxt  input  1  PHY NXT
ulpi_stp  output  1  link STP
ulpi_data_in  input  8  bus value sampled from the pins
ulpi_data_out  output  8  value the link drives
ulpi_data_oe  output  1  tristate enable; the top level builds the inout
rxcmd_valid  output  1  RX CMD captured (optional feature)
rxcmd_byte  output  8  last RX CMD byte (optional feature)

Behaviour:
- Reset values: ulpi_stp=0, ulpi_data_out=8'h00, ulpi_data_oe=0, rsp_valid=0, rsp_error=0, rsp_rdata=8'h00, rxcmd_valid=0, rxcmd_byte=8'h00, state=IDLE.
- req_ready = (state==IDLE) & ~reset.
- ulpi_data_oe = drive_q & ~ulpi_dir, combinational. The link releases the bus in the same cycle DIR rises.
- States: IDLE, CMD, WDATA, STOP, RD_TURN, RD_DATA, RD_END, ABORT_WAIT.
- IDLE: drive 8'h00 with oe requested. On req_valid & req_ready, latch write/addr/wdata and go to CMD.
- CMD: drive {req_write ? 2'b10 : 2'b11, addr}.
  - Sampled dir=1 -> ABORT_WAIT.
  - Else nxt=1 -> WDATA (write) or RD_TURN (read).
  - Else hold.
- ABORT_WAIT: oe off. When dir=0, return to CMD and reissue the same TX CMD. No timeout counting here.
- WDATA: drive wdata. On nxt=1 -> STOP.
- STOP: ulpi_stp=1 and data 8'h00 for exactly 1 cycle, rsp_valid=1 with rsp_error=0, then IDLE. Write latency from CMD entry with an immediate NXT is 3 cycles.
- RD_TURN: oe off; expects dir=1 (turnaround).
  - dir=1 & nxt=1 -> USB receive abort -> ABORT_WAIT.
  - dir=1 & nxt=0 -> RD_DATA.
- RD_DATA: capture ulpi_data_in into rsp_rdata -> RD_END.
- RD_END: wait for dir=0, then pulse rsp_valid (rsp_error=0) -> IDLE. Minimum read latency after NXT is 3 cycles.
- Timeout:
  - A counter clears on every state change and counts in CMD, WDATA, RD_TURN and RD_END.
  - When it reaches TIMEOUT_CYCLES: rsp_valid=1 with rsp_error=1, rsp_rdata unchanged.
  - From WDATA, the timeout goes via a 1-cycle STOP pulse. From other states it goes directly to IDLE.
- PHY power-up: DIR held high after reset simply parks CMD in ABORT_WAIT.
- Reset mid-operation: immediate return to IDLE with oe=0 and stp=0. The request is discarded and no rsp is produced.
- req_valid while not ready is ignored. The requester must hold it.

Optional Feature:
- Macro ULPI_RXCMD_CAPTURE_EN.
- Defined: when dir=1 and nxt=0 in a cycle that is not a turnaround (dir was 1 the previous cycle) and the state is not RD_DATA, latch ulpi_data_in into rxcmd_byte and pulse rxcmd_valid for 1 cycle.
- Undefined: rxcmd_valid and rxcmd_byte are tied to 0. The ports remain so the top level is unchanged.

Decomposition:
- Shared package/include ulpi_defs:
  - state encodings
  - TX CMD prefixes (2'b10 REGW, 2'b11 REGR)
  - ULPI_IDLE = 8'h00
  - register addresses VENDOR_ID_LOW = 6'h00 and VENDOR_ID_HIGH = 6'h01
- One natural sub-module, ulpi_reg_timer: a loadable/clearable progress counter that outputs an expired flag.

Test Plan:
- Read of addr 6'h01: cmd accepted, NXT in cycle 1, DIR high for 3 cycles with 8'h04 on the data cycle -> bus showed 8'hC1, rsp_valid one pulse after DIR falls, rsp_rdata=8'h04, rsp_error=0, oe low whenever dir=1.
- Write of 8'h55 to 6'h0A with NXT delayed 2 cycles on cmd and data -> bus shows 8'h8A then 8'h55, ulpi_stp 1 cycle with data 8'h00, rsp_valid=1, no bus contention.
- DIR rises during CMD before NXT (RX CMD 8'h4D for 5 cycles) -> oe drops the same cycle, TX CMD reissued after DIR falls; with ULPI_RXCMD_CAPTURE_EN, rxcmd_byte=8'h4D.
- NXT never asserted, TIMEOUT_CYCLES=8 -> rsp_valid with rsp_error=1 exactly 8 cycles after CMD entry, back in IDLE, req_ready=1.
- Read where PHY raises dir and nxt together in RD_TURN -> ABORT_WAIT, retry completes with correct data.
- Reset asserted in RD_DATA -> outputs at reset values immediately, no rsp_valid, next request works normally.
